// File: rtl/vram_burst_if.sv
// vram_burst_if
//   Bus bundle between the CPU/video clients and vram_burst_dpram.
//   master : drives port A strobes/data and burst requests, consumes the stream.
//   slave  : the RAM; returns a_rdata, burst stream and status.
//   Port A : a_en, a_we, a_addr, a_wdata -> a_rdata
//   Port B : b_start, b_base, b_len, b_abort, b_ready -> b_busy, b_valid, b_data, b_last
//   Status : init_busy
interface vram_burst_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 8
);
  logic                  a_en;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic                  b_start;
  logic [ADDR_WIDTH-1:0] b_base;
  logic [LEN_WIDTH-1:0]  b_len;
  logic                  b_abort;
  logic                  b_busy;
  logic                  b_valid;
  logic                  b_ready;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  b_last;
  logic                  init_busy;

  modport master (
    output a_en, a_we, a_addr, a_wdata, b_start, b_base, b_len, b_abort, b_ready,
    input  a_rdata, b_busy, b_valid, b_data, b_last, init_busy
  );

  modport slave (
    input  a_en, a_we, a_addr, a_wdata, b_start, b_base, b_len, b_abort, b_ready,
    output a_rdata, b_busy, b_valid, b_data, b_last, init_busy
  );
endinterface

// File: rtl/vram_burst_dpram.sv
// vram_burst_dpram
//   Single-clock dual-port video RAM.
//   Port A: random-access read/write, registered read data (1-cycle latency).
//   Port B: read-only burst engine (IDLE/RUN/DRAIN) streaming b_len words from
//           b_base over valid/ready, address wraps modulo depth, 2-entry output
//           buffer, abort, write-first bypass against a same-cycle port A write.
//   Ports : clk, reset (async, active high), bus (vram_burst_if.slave).
//   Option: define INIT_CLEAR_EN to zero the whole array after reset
//           (CLEAR state, init_busy high while it runs).
module vram_burst_dpram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 8
) (
  input logic         clk,
  input logic         reset,
  vram_burst_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_CLEAR} state_e;

`ifdef INIT_CLEAR_EN
  localparam state_e RST_STATE = S_CLEAR;
`else
  localparam state_e RST_STATE = S_IDLE;
`endif

  state_e                     state_q, state_d;
  logic [DATA_WIDTH-1:0]      mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]      a_rdata_q;
  logic [ADDR_WIDTH-1:0]      rd_addr_q, rd_addr_d;
  logic [LEN_WIDTH-1:0]       rem_q, rem_d;
  logic [1:0][DATA_WIDTH-1:0] buf_data_q;
  logic [1:0]                 buf_last_q;
  logic                       wr_ptr_q, rd_ptr_q;
  logic [1:0]                 cnt_q;

  logic                  clearing;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic                  a_wr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  b_valid, pop, issue, flush;

  // ---------------- optional post-reset clear ----------------
`ifdef INIT_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_addr_q;

  assign clearing = (state_q == S_CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         clr_addr_q <= '0;
    else if (clearing) clr_addr_q <= clr_addr_q + ADDR_WIDTH'(1);
  end

  assign mem_we = clearing | a_wr;
  assign mem_wa = clearing ? clr_addr_q : bus.a_addr;
  assign mem_wd = clearing ? '0 : bus.a_wdata;
`else
  assign clearing = 1'b0;
  assign mem_we   = a_wr;
  assign mem_wa   = bus.a_addr;
  assign mem_wd   = bus.a_wdata;
`endif

  // ---------------- storage and port A ----------------
  // Port A writes are dropped while the clear sweep owns the write port.
  assign a_wr = bus.a_en & bus.a_we & ~clearing;

  // Contents survive reset; only the clear sweep zeroes them.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         a_rdata_q <= '0;
    else if (bus.a_en && !bus.a_we)    a_rdata_q <= clearing ? '0 : mem_q[bus.a_addr];
  end

  // ---------------- burst datapath ----------------
  // Write-first: a burst read of the word port A is writing this very edge
  // must see the new data, not the array's old contents.
  assign rd_word = (a_wr && (bus.a_addr == rd_addr_q)) ? bus.a_wdata : mem_q[rd_addr_q];

  assign b_valid = (cnt_q != 2'd0);
  assign pop     = b_valid & bus.b_ready;

  // The read lands in the buffer at the issuing edge, so a full buffer may
  // still accept a read when its head leaves in the same cycle; that keeps
  // one word per cycle flowing under sustained b_ready.
  assign issue = (state_q == S_RUN) && !bus.b_abort && ((cnt_q != 2'd2) || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_data_q <= '0;
      buf_last_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (issue) begin
        buf_data_q[wr_ptr_q] <= rd_word;
        buf_last_q[wr_ptr_q] <= (rem_q == LEN_WIDTH'(1));
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, issue} - {1'b0, pop};
    end
  end

  // ---------------- burst FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RST_STATE;
      rd_addr_q <= '0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      rem_q     <= rem_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rem_d     = rem_q;
    flush     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Abort outranks a simultaneous start even with nothing to cancel.
        if (bus.b_start && !bus.b_abort && (bus.b_len != '0)) begin
          state_d   = S_RUN;
          rd_addr_d = bus.b_base;
          rem_d     = bus.b_len;
        end
      end
      S_RUN: begin
        if (bus.b_abort) begin
          state_d = S_IDLE;
          flush   = 1'b1;
        end else if (issue) begin
          rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);   // wraps at depth
          rem_d     = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.b_abort) begin
          state_d = S_IDLE;
          flush   = 1'b1;
        end else if (pop && buf_last_q[rd_ptr_q]) begin
          state_d = S_IDLE;
        end
      end
`ifdef INIT_CLEAR_EN
      S_CLEAR: begin
        if (clr_addr_q == '1) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_valid   = b_valid;
  assign bus.b_data    = buf_data_q[rd_ptr_q];
  assign bus.b_last    = b_valid & buf_last_q[rd_ptr_q];
  assign bus.b_busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.init_busy = clearing;
endmodule

// File: tb/tb_vram_burst_dpram.sv
module tb_vram_burst_dpram;
  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int LW    = 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vram_burst_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  vram_burst_dpram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] exp_rdata;
  logic          m_busy;
  logic          m_clearing;
  int            clr_cnt;
  logic [DW-1:0] exp_data [256];
  logic          exp_last [256];
  int            exp_n, exp_idx;
  logic          prev_stall;
  logic [DW-1:0] prev_d;
  logic          prev_l;
  int            cyc;
  logic [DW-1:0] got_d [$];
  logic          got_l [$];
  int            got_c [$];

  // One compare/advance step per cycle at the falling edge: check what the
  // DUT shows now, then apply the inputs that the next rising edge will see.
  initial begin
    cyc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_rdata  = '0;
        m_busy     = 1'b0;
        exp_n      = 0;
        exp_idx    = 0;
        prev_stall = 1'b0;
        clr_cnt    = 0;
`ifdef INIT_CLEAR_EN
        m_clearing = 1'b1;
`else
        m_clearing = 1'b0;
`endif
      end else begin
        logic busy_now, clr_now;
        chk("init_busy", bus.init_busy, m_clearing);
        chk("a_rdata", bus.a_rdata, exp_rdata);
        chk("b_busy", bus.b_busy, m_busy);
        if (prev_stall) begin
          chk("stall_valid", bus.b_valid, 1);
          chk("stall_data", bus.b_data, prev_d);
          chk("stall_last", bus.b_last, prev_l);
        end
        if (bus.b_valid) begin
          if (exp_idx < exp_n) begin
            chk("b_data", bus.b_data, exp_data[exp_idx]);
            chk("b_last", bus.b_last, exp_last[exp_idx]);
          end else begin
            chk("b_valid_unexpected", bus.b_valid, 0);
          end
        end

        busy_now   = m_busy;
        clr_now    = m_clearing;
        prev_stall = bus.b_valid & ~bus.b_ready;
        prev_d     = bus.b_data;
        prev_l     = bus.b_last;

        if (bus.b_valid && bus.b_ready && exp_idx < exp_n) begin
          got_d.push_back(bus.b_data);
          got_l.push_back(bus.b_last);
          got_c.push_back(cyc);
          if (exp_last[exp_idx]) m_busy = 1'b0;
          exp_idx++;
        end

        if (clr_now) begin
          if (bus.a_en && !bus.a_we) exp_rdata = '0;
          mem_m[clr_cnt] = '0;
          clr_cnt++;
          if (clr_cnt == DEPTH) m_clearing = 1'b0;
        end else if (bus.a_en) begin
          if (bus.a_we) mem_m[bus.a_addr] = bus.a_wdata;
          else          exp_rdata = mem_m[bus.a_addr];
        end

        if (busy_now && bus.b_abort) begin
          m_busy     = 1'b0;
          exp_n      = exp_idx;
          prev_stall = 1'b0;
        end else if (!busy_now && !clr_now && bus.b_start && !bus.b_abort && bus.b_len != 0) begin
          for (int i = 0; i < int'(bus.b_len); i++) begin
            exp_data[i] = mem_m[(int'(bus.b_base) + i) % DEPTH];
            exp_last[i] = (i == int'(bus.b_len) - 1);
          end
          exp_n   = int'(bus.b_len);
          exp_idx = 0;
          m_busy  = 1'b1;
        end
        cyc++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_en = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_start = 0; bus.b_base = '0; bus.b_len = '0; bus.b_abort = 0;
  endtask

  task automatic wr(input int addr, input int data);
    bus.a_en = 1; bus.a_we = 1; bus.a_addr = AW'(addr); bus.a_wdata = DW'(data);
    tick();
    bus.a_en = 0; bus.a_we = 0;
  endtask

  task automatic start_burst(input int base, input int len);
    bus.b_start = 1; bus.b_base = AW'(base); bus.b_len = LW'(len);
    tick();
    bus.b_start = 0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (m_busy && n < max) begin
      tick();
      n++;
    end
    chk(name, m_busy, 0);
  endtask

  task automatic clear_got();
    got_d.delete(); got_l.delete(); got_c.delete();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n, base, len, addr;
    idle_inputs();
    bus.b_ready = 0;
    reset = 1;
    @(negedge clk);
    chk("rst_a_rdata", bus.a_rdata, 0);
    chk("rst_b_valid", bus.b_valid, 0);
    chk("rst_b_last", bus.b_last, 0);
    chk("rst_b_data", bus.b_data, 0);
    chk("rst_b_busy", bus.b_busy, 0);
    @(posedge clk); #1;
    reset = 0;

`ifdef INIT_CLEAR_EN
    n = 0;
    while (bus.init_busy && n < 3000) begin
      if (n == 10) begin bus.a_en = 1; bus.a_we = 0; bus.a_addr = AW'(12'h3F0); end
      if (n == 20) begin bus.a_en = 1; bus.a_we = 1; bus.a_addr = AW'(5); bus.a_wdata = 8'hFF; end
      tick();
      bus.a_en = 0; bus.a_we = 0;
      n++;
    end
    chk("init_busy_cycles", n, 1024);
    clear_got();
    bus.b_ready = 1;
    start_burst(0, 8);
    wait_idle("clr_burst_done", 100);
    chk("clr_burst_count", got_d.size(), 8);
    foreach (got_d[i]) chk("clr_burst_zero", got_d[i], 0);
`endif

    // Fill the whole array so every later read has a known model value.
    for (int a = 0; a < DEPTH; a++) begin
      bus.a_en = 1; bus.a_we = 1; bus.a_addr = AW'(a); bus.a_wdata = DW'($urandom);
      tick();
    end
    idle_inputs();

    // Port A write then read: data exactly one cycle after the read strobe.
    wr(12'h010, 8'h5A);
    bus.a_en = 1; bus.a_we = 0; bus.a_addr = AW'(12'h010);
    tick();
    bus.a_en = 0;
    chk("pa_read_5A", bus.a_rdata, 8'h5A);

    // 16-word burst at full rate.
    for (int i = 0; i < 16; i++) wr(i, i);
    clear_got();
    bus.b_ready = 1;
    start_burst(0, 16);
    wait_idle("t16_done", 100);
    chk("t16_count", got_d.size(), 16);
    for (int i = 0; i < got_d.size(); i++) begin
      chk("t16_word", got_d[i], i);
      chk("t16_last", got_l[i], (i == 15));
      if (i > 0) chk("t16_no_bubble", got_c[i] - got_c[i-1], 1);
    end

    // Wrap-around.
    wr(12'h3FE, 8'hA1); wr(12'h3FF, 8'hA2); wr(12'h000, 8'hA3); wr(12'h001, 8'hA4);
    clear_got();
    start_burst(12'h3FE, 4);
    wait_idle("wrap_done", 100);
    chk("wrap_count", got_d.size(), 4);
    if (got_d.size() == 4) begin
      chk("wrap_w0", got_d[0], 8'hA1); chk("wrap_w1", got_d[1], 8'hA2);
      chk("wrap_w2", got_d[2], 8'hA3); chk("wrap_w3", got_d[3], 8'hA4);
    end

    // Zero-length request is a no-op.
    start_burst(5, 0);
    chk("len0_busy", bus.b_busy, 0);
    tick();
    chk("len0_valid", bus.b_valid, 0);

    // Backpressure 1,0,0 pattern; a start while busy must be ignored.
    for (int i = 0; i < 8; i++) wr(12'h100 + i, 8'h80 + i);
    clear_got();
    bus.b_ready = 1;
    start_burst(12'h100, 8);
    n = 0;
    while (m_busy && n < 200) begin
      bus.b_ready = (n % 3 == 0);
      bus.b_start = (n == 5); bus.b_base = AW'(12'h200); bus.b_len = LW'(3);
      tick();
      n++;
    end
    bus.b_start = 0;
    chk("bp_done", m_busy, 0);
    chk("bp_count", got_d.size(), 8);
    for (int i = 0; i < got_d.size(); i++) chk("bp_word", got_d[i], 8'h80 + i);

    // Write-first collision on burst word 3.
    wr(12'h205, 8'h11);
    clear_got();
    bus.b_ready = 1;
    start_burst(12'h202, 8);
    tick(); tick(); tick();
    exp_data[3] = 8'hC3;
    bus.a_en = 1; bus.a_we = 1; bus.a_addr = AW'(12'h205); bus.a_wdata = 8'hC3;
    tick();
    bus.a_en = 0; bus.a_we = 0;
    wait_idle("coll_done", 100);
    chk("coll_count", got_d.size(), 8);
    if (got_d.size() > 3) chk("coll_word3", got_d[3], 8'hC3);

    // Abort after 3 handshakes with a simultaneous start.
    for (int i = 0; i < 10; i++) wr(12'h300 + i, 8'h40 + i);
    clear_got();
    bus.b_ready = 1;
    start_burst(12'h300, 10);
    n = 0;
    while (got_d.size() < 3 && n < 50) begin
      tick();
      n++;
    end
    chk("abort_pre_count", got_d.size(), 3);
    bus.b_ready = 0; bus.b_abort = 1;
    bus.b_start = 1; bus.b_base = AW'(0); bus.b_len = LW'(5);
    tick();
    bus.b_abort = 0; bus.b_start = 0; bus.b_ready = 1;
    chk("abort_valid", bus.b_valid, 0);
    chk("abort_busy", bus.b_busy, 0);
    repeat (5) tick();
    chk("abort_no_more", got_d.size(), 3);
    start_burst(12'h300, 10);
    wait_idle("abort_restart_done", 100);
    chk("abort_restart_count", got_d.size(), 13);
    if (got_d.size() == 13) begin
      chk("abort_restart_first", got_d[3], 8'h40);
      chk("abort_restart_last", got_d[12], 8'h49);
    end

    // Randomized bursts with concurrent port A traffic outside the burst range.
    for (int b = 0; b < 40; b++) begin
      base = $urandom_range(0, DEPTH - 1);
      len  = $urandom_range(1, 24);
      bus.b_ready = $urandom_range(0, 1);
      start_burst(base, len);
      n = 0;
      while (m_busy && n < 600) begin
        bus.b_ready = ($urandom_range(0, 3) != 0);
        addr = $urandom_range(0, DEPTH - 1);
        bus.a_en = $urandom_range(0, 1);
        bus.a_addr = AW'(addr);
        bus.a_wdata = DW'($urandom);
        bus.a_we = (((addr - base + DEPTH) % DEPTH) < len) ? 1'b0 : 1'($urandom_range(0, 1));
        bus.b_start = ($urandom_range(0, 7) == 0);
        bus.b_abort = ($urandom_range(0, 59) == 0);
        tick();
        n++;
      end
      idle_inputs();
      chk("rand_done", m_busy, 0);
      tick();
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
